// File: rtl/chinpo_mem_responder_if.sv
// Request/response bundle between the CHINPO control unit (master) and the memory responder (slave).
// Strobes, address and store data flow to memory; load data, ready and status flags flow back.
interface chinpo_mem_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              mem_ready;
  logic              busy;
  logic              addr_err;
  logic              proto_err;

  modport master (
    output mem_read, mem_write, addr, write_data,
    input  read_data, mem_ready, busy, addr_err, proto_err
  );

  modport slave (
    input  mem_read, mem_write, addr, write_data,
    output read_data, mem_ready, busy, addr_err, proto_err
  );
endinterface

// File: rtl/chinpo_mem_responder.sv
// Memory-side responder: latches one request, waits WAIT_STATES cycles, accesses an
// internal word array and returns data with a one-cycle ready pulse plus error flags.
module chinpo_mem_responder #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  chinpo_mem_responder_if.slave  io_bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  generate
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
      $error("WAIT_STATES must be in 0..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_is_write;
  logic [DATA_W-1:0] r_read_data;
  logic              r_addr_err;
  logic              r_proto_err;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_mem_q;

  logic              w_strobe;
  logic              w_accept;
  logic              w_err;
  logic [31:0]       w_word_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [IDX_W-1:0]  w_acc_idx;

  assign w_strobe   = io_bus.mem_read | io_bus.mem_write;
  assign w_word_idx = 32'(r_addr[ADDR_W-1:1]);
  assign w_err      = r_addr[0] | (w_word_idx >= 32'(DEPTH));
  assign w_acc_idx  = r_addr[IDX_W:1];
  // Steer the array read to the incoming address while idle so the word is ready by ACCESS even with no wait states.
  assign w_rd_idx   = (r_state == S_IDLE) ? io_bus.addr[IDX_W:1] : r_addr[IDX_W:1];

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_strobe) begin
          w_accept     = 1'b1;
          w_state_next = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_ACCESS;
        end
      end
      S_ACCESS: w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_is_write  <= 1'b0;
      r_read_data <= '0;
      r_addr_err  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_addr     <= io_bus.addr;
        r_wdata    <= io_bus.write_data;
        r_is_write <= io_bus.mem_write;
        r_addr_err <= 1'b0;
        r_cnt      <= WS_LOAD;
        if (io_bus.mem_read && io_bus.mem_write) begin
          r_proto_err <= 1'b1;
        end
      end
      if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == S_ACCESS) begin
        r_addr_err <= w_err;
        if (!r_is_write) begin
          r_read_data <= w_err ? '0 : r_mem_q;
        end
      end
    end
  end

  // Array kept free of reset so it maps onto block RAM; an aborted write never reaches ACCESS.
  always_ff @(posedge i_clk) begin
    if (r_state == S_ACCESS && r_is_write && !w_err) begin
      r_mem[w_acc_idx] <= r_wdata;
    end
    r_mem_q <= r_mem[w_rd_idx];
  end

  assign io_bus.read_data = r_read_data;
  assign io_bus.mem_ready = (r_state == S_DONE);
  assign io_bus.busy      = (r_state != S_IDLE);
  assign io_bus.addr_err  = r_addr_err;
  assign io_bus.proto_err = r_proto_err;
endmodule
